// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the
// program loader, the core data port and the core instruction fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      ldr_active_i,
  input  logic [2:0]                req_i,
  input  logic [2:0]                we_i,
  input  logic [3*ADDR_WIDTH-1:0]   addr_i,
  input  logic [3*DATA_WIDTH-1:0]   wdata_i,
  input  logic [3*DATA_WIDTH/8-1:0] be_i,
  output logic [2:0]                gnt_o,
  output logic [2:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      core_hold_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] gnt;
  logic       fetch_win;

  // Boot sequencing: loader owns memory until it lets go and
  // its last read response has been delivered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (!ldr_active_i && !pend_q[0]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ldr_active_i) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Grant decode: loader only in LOAD; data over fetch in RUN
  // unless fetch has been starved for STARVE_LIMIT cycles.
  always_comb begin
    gnt       = 3'b000;
    fetch_win = (starve_q == LIM);
    if (state_q == LOAD) begin
      gnt[0] = req_i[0];
    end else if (!ldr_active_i) begin
      unique case (1'b1)
        (req_i[2] && (fetch_win || !req_i[1])):
          gnt = 3'b100;
        (req_i[1] && !(req_i[2] && fetch_win)):
          gnt = 3'b010;
        default:
          gnt = 3'b000;
      endcase
    end
  end

  // Starvation counter: counts denied fetch cycles, frozen in LOAD.
  always_comb begin
    starve_d = starve_q;
    if (state_q == RUN) begin
      if (req_i[2] && !gnt[2]) begin
        if (starve_q != LIM) begin
          starve_d = starve_q + 4'd1;
        end
      end else begin
        starve_d = 4'd0;
      end
    end
  end

  // Memory port mux from the single granted requester.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    for (int k = 0; k < 3; k++) begin
      if (gnt[k]) begin
        mem_we_o    = we_i[k];
        mem_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        mem_be_o    = be_i[k*BW +: BW];
      end
    end
  end

  // Read grants mark which port owns next cycle's read data.
  always_comb begin
    pend_d = gnt & ~we_i;
  end

  // State, starvation and pending-response registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= LOAD;
      starve_q <= 4'd0;
      pend_q   <= 3'b000;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  assign gnt_o       = gnt;
  assign mem_en_o    = |gnt;
  assign rvalid_o    = pend_q;
  assign rdata_o     = mem_rdata_i;
  assign core_hold_o = (state_q == LOAD);

  // Grant must never select more than one requester.
  a_gnt_onehot: assert property (
    @(posedge clk_i) disable iff (arst_i) $onehot0(gnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter against a small
// byte-enabled synchronous memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        ldr;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [95:0] addr;
  logic [95:0] wdata;
  logic [11:0] be;

  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [31:0] rdata;
  logic        hold;
  logic        men;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mbe;
  logic [31:0] mrdata;

  logic [2:0]  gnt1;
  logic [2:0]  rvalid1;
  logic [31:0] rdata1;
  logic        hold1;
  logic        men1;
  logic        mwe1;
  logic [31:0] maddr1;
  logic [31:0] mwdata1;
  logic [3:0]  mbe1;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)
  ) u_dut (
    .clk_i(clk), .arst_i(arst), .ldr_active_i(ldr),
    .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .core_hold_o(hold), .mem_en_o(men), .mem_we_o(mwe),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_be_o(mbe), .mem_rdata_i(mrdata)
  );

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(1)
  ) u_dut1 (
    .clk_i(clk), .arst_i(arst), .ldr_active_i(ldr),
    .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
    .core_hold_o(hold1), .mem_en_o(men1), .mem_we_o(mwe1),
    .mem_addr_o(maddr1), .mem_wdata_o(mwdata1),
    .mem_be_o(mbe1), .mem_rdata_i(32'd0)
  );

  // Memory model: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (men) begin
      if (mwe) begin
        for (int b = 0; b < 4; b++) begin
          if (mbe[b]) mem[maddr[7:2]][b*8 +: 8] <= mwdata[b*8 +: 8];
        end
      end else begin
        mrdata <= mem[maddr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    req = 3'b000; we = 3'b000;
    addr = '0; wdata = '0; be = '0;
  endtask

  task automatic put(input int k, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    req[k] = 1'b1;
    we[k] = w;
    addr[k*32 +: 32] = a;
    wdata[k*32 +: 32] = d;
    be[k*4 +: 4] = b;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] e0;
  logic [2:0] e1;

  initial begin
    mrdata = 32'd0;
    arst = 1'b1;
    ldr = 1'b1;
    clr();
    look();
    chk("rst_hold", 64'(hold), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    tick();
    arst = 1'b0;

    // Core requests blocked while in LOAD.
    for (int i = 0; i < 2; i++) begin
      clr();
      put(1, 1'b0, 32'h20, 32'h0, 4'hf);
      put(2, 1'b0, 32'h24, 32'h0, 4'hf);
      look();
      chk("load_blk_gnt", 64'(gnt), 64'd0);
      chk("load_blk_en", 64'(men), 64'd0);
      chk("load_blk_hold", 64'(hold), 64'd1);
      tick();
    end

    // Loader write then read.
    clr();
    put(0, 1'b1, 32'h10, 32'hdeadbeef, 4'hf);
    look();
    chk("ldr_wr_gnt", 64'(gnt), 64'b001);
    chk("ldr_wr_we", 64'(mwe), 64'd1);
    chk("ldr_wr_addr", 64'(maddr), 64'h10);
    chk("ldr_wr_hold", 64'(hold), 64'd1);
    tick();
    clr();
    put(0, 1'b0, 32'h10, 32'h0, 4'hf);
    look();
    chk("ldr_rd_gnt", 64'(gnt), 64'b001);
    chk("ldr_rd_en", 64'(men), 64'd1);
    chk("ldr_rd_rvalid", 64'(rvalid), 64'd0);
    tick();

    // Drop loader while its read is still pending.
    clr();
    ldr = 1'b0;
    look();
    chk("ldr_rv", 64'(rvalid), 64'b001);
    chk("ldr_rdata", 64'(rdata), 64'hdeadbeef);
    chk("drop_hold0", 64'(hold), 64'd1);
    tick();
    look();
    chk("drop_hold1", 64'(hold), 64'd1);
    chk("drop_rv1", 64'(rvalid), 64'd0);
    tick();
    look();
    chk("drop_hold2", 64'(hold), 64'd0);
    tick();

    // Fetch-port write and partial data-port write.
    clr();
    put(2, 1'b1, 32'h24, 32'h33334444, 4'hf);
    look();
    chk("f_wr_gnt", 64'(gnt), 64'b100);
    chk("f_wr_we", 64'(mwe), 64'd1);
    chk("f_wr_addr", 64'(maddr), 64'h24);
    chk("f_wr_data", 64'(mwdata), 64'h33334444);
    tick();
    clr();
    put(1, 1'b1, 32'h20, 32'h11112222, 4'hf);
    look();
    chk("d_wr_gnt", 64'(gnt), 64'b010);
    tick();
    clr();
    put(1, 1'b1, 32'h20, 32'haaaa5555, 4'h3);
    look();
    chk("d_wr_be", 64'(mbe), 64'h3);
    chk("d_wr_wdata", 64'(mwdata), 64'haaaa5555);
    tick();

    // Response routing: data read then fetch read back to back.
    clr();
    put(1, 1'b0, 32'h20, 32'h0, 4'hf);
    look();
    chk("rt_gnt_d", 64'(gnt), 64'b010);
    chk("rt_we_d", 64'(mwe), 64'd0);
    tick();
    clr();
    put(2, 1'b0, 32'h24, 32'h0, 4'hf);
    look();
    chk("rt_gnt_f", 64'(gnt), 64'b100);
    chk("rt_rv_d", 64'(rvalid), 64'b010);
    chk("rt_rdata_d", 64'(rdata), 64'h11115555);
    tick();
    clr();
    look();
    chk("rt_rv_f", 64'(rvalid), 64'b100);
    chk("rt_rdata_f", 64'(rdata), 64'h33334444);
    chk("idle_en", 64'(men), 64'd0);
    chk("idle_addr", 64'(maddr), 64'd0);
    tick();

    // Priority with starvation guard, both limits side by side.
    for (int i = 0; i < 10; i++) begin
      clr();
      put(1, 1'b0, 32'h20, 32'h0, 4'hf);
      put(2, 1'b0, 32'h24, 32'h0, 4'hf);
      e0 = (i % 5 == 4) ? 3'b100 : 3'b010;
      e1 = (i % 2 == 1) ? 3'b100 : 3'b010;
      look();
      chk($sformatf("prio4_%0d", i), 64'(gnt), 64'(e0));
      chk($sformatf("prio1_%0d", i), 64'(gnt1), 64'(e1));
      tick();
    end
    clr();
    tick();

    // Loader takeover with a data read in flight.
    clr();
    put(1, 1'b0, 32'h20, 32'h0, 4'hf);
    look();
    chk("tk_gnt0", 64'(gnt), 64'b010);
    tick();
    ldr = 1'b1;
    look();
    chk("tk_gnt1", 64'(gnt), 64'd0);
    chk("tk_en1", 64'(men), 64'd0);
    chk("tk_rv1", 64'(rvalid), 64'b010);
    chk("tk_rdata1", 64'(rdata), 64'h11115555);
    chk("tk_hold1", 64'(hold), 64'd0);
    tick();
    look();
    chk("tk_hold2", 64'(hold), 64'd1);
    chk("tk_gnt2", 64'(gnt), 64'd0);
    chk("tk_rv2", 64'(rvalid), 64'd0);
    tick();

    // Back to RUN, build up starvation, reset mid-read.
    clr();
    ldr = 1'b0;
    tick();
    look();
    chk("rr_hold", 64'(hold), 64'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      clr();
      put(1, 1'b0, 32'h20, 32'h0, 4'hf);
      put(2, 1'b0, 32'h24, 32'h0, 4'hf);
      look();
      chk($sformatf("pre_rst_%0d", i), 64'(gnt), 64'b010);
      if (i == 1) begin
        #1;
        arst = 1'b1;
        #1;
        chk("arst_rv", 64'(rvalid), 64'd0);
        chk("arst_hold", 64'(hold), 64'd1);
      end
      tick();
    end
    chk("arst_rv_drop", 64'(rvalid), 64'd0);
    arst = 1'b0;
    clr();
    look();
    chk("post_rst_hold", 64'(hold), 64'd1);
    tick();

    // Starvation count must restart from zero.
    for (int i = 0; i < 5; i++) begin
      clr();
      put(1, 1'b0, 32'h20, 32'h0, 4'hf);
      put(2, 1'b0, 32'h24, 32'h0, 4'hf);
      e0 = (i == 4) ? 3'b100 : 3'b010;
      look();
      chk($sformatf("post_prio_%0d", i), 64'(gnt), 64'(e0));
      tick();
    end
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
